// File: rtl/riscv_pkg.sv
// Shared constants for the RISC-V core.
//   DEFAULT_XLEN         - default address/data width
//   DEFAULT_RESET_VECTOR - default PC value after reset
//   DEFAULT_IALIGN       - default instruction alignment in bits (16 or 32)
//   PC_INCR              - sequential fetch increment in bytes
package riscv_pkg;

  localparam int unsigned DEFAULT_XLEN         = 32;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
  localparam int unsigned DEFAULT_IALIGN       = 32;
  localparam int unsigned PC_INCR              = 4;

endpackage

// File: rtl/program_counter.sv
// Architectural PC register for the fetch stage.
// Ports:
//   clk           - system clock, rising-edge active
//   rst           - asynchronous active-high reset; forces pc_out to RESET_VECTOR
//   PCWrite       - load enable from the hazard unit; 0 holds the PC
//   pc_next       - next PC from the next-PC mux, stored unmodified
//   pc_out        - current PC (registered)
//   pc_plus4      - pc_out + 4, wraps modulo 2^XLEN
//   pc_misaligned - pc_out violates IALIGN
//   pc_valid      - 0 in reset, 1 from the first rising edge after reset release
module program_counter
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN         = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter int unsigned     IALIGN       = DEFAULT_IALIGN
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            PCWrite,
  input  logic [XLEN-1:0] pc_next,
  output logic [XLEN-1:0] pc_out,
  output logic [XLEN-1:0] pc_plus4,
  output logic            pc_misaligned,
  output logic            pc_valid
);

  if ((IALIGN != 16 && IALIGN != 32) || XLEN < 3) begin : gen_param_check
    $fatal(1, "program_counter: IALIGN must be 16 or 32 and XLEN must be >= 3");
  end

  logic [XLEN-1:0] pc_q;
  logic            valid_q;

  // An X on PCWrite evaluates as false in the if, so the PC holds rather than
  // picking up an unknown value.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q    <= RESET_VECTOR;
      valid_q <= 1'b0;
    end else begin
      valid_q <= 1'b1;
      if (PCWrite) begin
        pc_q <= pc_next;
      end
    end
  end

  assign pc_out   = pc_q;
  assign pc_valid = valid_q;
  assign pc_plus4 = pc_q + XLEN'(PC_INCR);

  if (IALIGN == 32) begin : gen_ialign32
    assign pc_misaligned = |pc_q[1:0];
  end else begin : gen_ialign16
    assign pc_misaligned = pc_q[0];
  end

  a_pcwrite_known : assert property (@(posedge clk) disable iff (rst) !$isunknown(PCWrite))
    else $error("program_counter: PCWrite is X/Z while out of reset");

  a_pc_next_known : assert property (@(posedge clk) disable iff (rst) !$isunknown(pc_next))
    else $error("program_counter: pc_next is X/Z while out of reset");

endmodule

// File: tb/tb_program_counter.sv
module tb_program_counter;

  localparam int unsigned XLEN = 32;
  localparam logic [31:0] RV   = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        PCWrite;
  logic [31:0] pc_next;

  logic [31:0] pc_out_a, pc_plus4_a, pc_out_b, pc_plus4_b;
  logic        mis_a, mis_b, valid_a, valid_b;

  int errors = 0;
  int checks = 0;

  // Reference state
  logic [31:0] m_pc;
  bit          m_valid;

  always #5 clk = ~clk;

  program_counter #(.XLEN(XLEN), .RESET_VECTOR(RV), .IALIGN(32)) dut32 (
    .clk          (clk),
    .rst          (rst),
    .PCWrite      (PCWrite),
    .pc_next      (pc_next),
    .pc_out       (pc_out_a),
    .pc_plus4     (pc_plus4_a),
    .pc_misaligned(mis_a),
    .pc_valid     (valid_a)
  );

  program_counter #(.XLEN(XLEN), .RESET_VECTOR(RV), .IALIGN(16)) dut16 (
    .clk          (clk),
    .rst          (rst),
    .PCWrite      (PCWrite),
    .pc_next      (pc_next),
    .pc_out       (pc_out_b),
    .pc_plus4     (pc_plus4_b),
    .pc_misaligned(mis_b),
    .pc_valid     (valid_b)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    longint unsigned sum;
    logic [31:0]     exp_plus4;
    sum       = longint'(m_pc) + 64'd4;
    exp_plus4 = sum[31:0];
    chk({tag, ".pc32"},    pc_out_a, m_pc);
    chk({tag, ".pc16"},    pc_out_b, m_pc);
    chk({tag, ".plus4_32"}, pc_plus4_a, exp_plus4);
    chk({tag, ".plus4_16"}, pc_plus4_b, exp_plus4);
    chk({tag, ".mis32"},   {31'd0, mis_a}, {31'd0, (m_pc % 4) != 0});
    chk({tag, ".mis16"},   {31'd0, mis_b}, {31'd0, (m_pc % 2) != 0});
    chk({tag, ".valid32"}, {31'd0, valid_a}, {31'd0, m_valid});
    chk({tag, ".valid16"}, {31'd0, valid_b}, {31'd0, m_valid});
  endtask

  // Drive on the falling edge, let one rising edge happen, then check.
  task automatic step(input string tag, input bit r, input bit we, input logic [31:0] nx);
    @(negedge clk);
    rst     = r;
    PCWrite = we;
    pc_next = nx;
    @(posedge clk);
    if (r) begin
      m_pc    = RV;
      m_valid = 0;
    end else begin
      m_valid = 1;
      if (we) m_pc = nx;
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    // Reset at time zero
    rst     = 1'b1;
    PCWrite = 1'b1;
    pc_next = 32'd0;
    m_pc    = RV;
    m_valid = 0;
    #1;
    check_all("reset");

    // Release at 10ns together with the first load
    step("load4", 0, 1, 32'd4);
    step("load8", 0, 1, 32'd8);
    step("stall", 0, 0, 32'd12);
    step("load100", 0, 1, 32'd100);

    // Asynchronous reset between edges
    @(negedge clk);
    #2;
    rst = 1'b1;
    m_pc    = RV;
    m_valid = 0;
    #1;
    check_all("async_rst");
    step("rel_load200", 0, 1, 32'd200);

    // Boundaries
    step("wrap", 0, 1, 32'hFFFF_FFFC);
    step("mis102", 0, 1, 32'h0000_0102);
    step("mis101", 0, 1, 32'h0000_0101);

    // Reset released while stalled
    step("rst_hold", 1, 1, 32'h55);
    step("rel_stall0", 0, 0, 32'h40);
    step("rel_stall1", 0, 0, 32'h44);
    step("rel_load48", 0, 1, 32'h48);

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      bit          r, we;
      logic [31:0] nx;
      r  = ($urandom_range(0, 15) == 0);
      we = ($urandom_range(0, 3) != 0);
      nx = $urandom();
      if ($urandom_range(0, 1) == 0) nx[1:0] = 2'b00;
      step("rand", r, we, nx);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/program_counter.md
Name: program_counter

Overview:
- Architectural PC register for the fetch stage of the 5-stage pipelined RISC-V core.
- Holds the address of the instruction being fetched and loads `pc_next` each cycle unless the hazard unit stalls it with `PCWrite` low.
- `pc_next` comes from the fetch next-PC mux: PC+4, branch/jump target, or trap vector.
- Also supplies combinational PC+4 and an alignment flag to fetch and exception logic.

Parameters:
- XLEN, 32, address width of PC and all PC-related ports.
- RESET_VECTOR, 32'h0000_0000, value loaded into PC on reset.
- IALIGN, 32, instruction alignment in bits; legal values 32 or 16. It sets which low PC bits must be zero.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  asynchronous, active-high reset.
- PCWrite  input  1  PC write enable from hazard unit; 0 = stall (hold PC).
- pc_next  input  XLEN  next PC value chosen by the next-PC mux.
- pc_out  output  XLEN  current PC (registered).
- pc_plus4  output  XLEN  pc_out + 4 (combinational).
- pc_misaligned  output  1  pc_out violates IALIGN (combinational).
- pc_valid  output  1  low during reset; high from the first rising edge after reset deassertion.

Behaviour:
- Reset (already decided): one clock `clk`; reset `rst` is asynchronous and active-high.
  - While rst=1: pc_out = RESET_VECTOR immediately, regardless of clk.
  - Also during reset: pc_valid = 0, and pc_plus4/pc_misaligned follow from RESET_VECTOR.
- Normal update, on each rising clk with rst=0:
  - PCWrite=1: pc_out <= pc_next.
  - PCWrite=0: pc_out holds; pc_next is ignored.
- Latency: pc_next is visible on pc_out one rising edge after it is sampled. There is no combinational path from pc_next to pc_out.
- pc_valid: flop cleared by rst, set to 1 on the first rising edge with rst=0, then stays 1 until the next reset. It is independent of PCWrite.
- pc_plus4 = pc_out + 4, modulo 2^XLEN. Wrap-around: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.
- pc_misaligned:
  - IALIGN=32: pc_misaligned = |pc_out[1:0].
  - IALIGN=16: pc_misaligned = pc_out[0].
- pc_next is stored unmodified; low bits are not masked. Handling a misaligned PC is the exception unit's job.
- Simultaneous events:
  - rst overrides PCWrite and pc_next.
  - Reset asserted mid-run clears the PC asynchronously, mid-cycle if necessary.
  - On reset release, the first rising edge with PCWrite=1 loads pc_next.
- X-safety: if PCWrite is X, the PC must not silently update in synthesis. A simulation assertion flags X on PCWrite or pc_next when rst=0.
- Elaboration check: fatal error if IALIGN is not 16 or 32, or if XLEN < 3.

Decomposition:
- Shared package `riscv_pkg`: XLEN constant, RESET_VECTOR default, IALIGN default, and the PC-increment constant (4).
- No sub-module needed; a single module containing:
  - the PC flop
  - the valid flop
  - combinational adder and alignment logic
  - assertions

Test Plan:
- Reset: rst=1 at t=0 with pc_next=0 and PCWrite=1 -> pc_out=0 and pc_valid=0. Deassert at 10ns -> pc_valid=1 after the next edge.
- Sequential load: PCWrite=1, pc_next=4 then 8 on consecutive cycles -> pc_out=4 then 8, one edge after each is applied. pc_plus4=8 then 12.
- Stall: PCWrite=0, pc_next=12 -> pc_out stays 8 across the edge. Then PCWrite=1, pc_next=100 -> pc_out=100 after the next edge.
- Mid-run reset: pc_out=100, assert rst=1 between clock edges -> pc_out=0 immediately, without waiting for clk. Release, pc_next=200 -> pc_out=200 after one edge.
- Boundary: load 32'hFFFF_FFFC -> pc_plus4=0. Load 32'h0000_0102 with IALIGN=32 -> pc_misaligned=1; with IALIGN=16 -> pc_misaligned=0.
- Stall during reset release: rst falls while PCWrite=0 -> pc_out stays RESET_VECTOR until the first edge with PCWrite=1.
